// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: latches the four nibbles once per frame,
// then time-multiplexes them with hex decode, decimal points and leading-zero blanking.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] dp_sel,
    input  logic       blank_lz,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;

    logic [CW-1:0]      div_cnt;
    logic [1:0]         dig;
    logic [3:0][3:0]    snap;
    logic [3:0]         snap_dp;
    logic               snap_lz;
    logic               load_pend;

    logic               tick;
    logic               load;
    logic [3:0]         cur_val;
    logic               higher_zero;
    logic               blank;
    logic [6:0]         seg_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick = en && (div_cnt == DIV_LAST);
    // The last slot of a frame is where the next frame's snapshot is taken.
    assign load = tick && (dig == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            dig     <= 2'd0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                dig     <= dig + 2'd1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap    <= '0;
            snap_dp <= 4'h0;
            snap_lz <= 1'b0;
        end else if (load) begin
            snap    <= {in3, in2, in1, in0};
            snap_dp <= dp_sel;
            snap_lz <= blank_lz;
        end
    end

    always_comb begin
        cur_val     = snap[dig];
        higher_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i >= int'(dig)) && (snap[i] != 4'h0)) begin
                higher_zero = 1'b0;
            end
        end
        blank   = snap_lz && (dig != 2'd0) && higher_zero;
        seg_lit = ACTIVE_LOW_SEG ? ~hex_to_seg(cur_val) : hex_to_seg(cur_val);
    end

    // load_pend bridges the snapshot edge to the first displayed digit-0 cycle,
    // so the pulse survives an enable gap landing right at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 4'b1111;
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
            load_pend   <= 1'b0;
        end else begin
            frame_start <= en && (dig == 2'd0) && load_pend;
            if (load) begin
                load_pend <= 1'b1;
            end else if (en && (dig == 2'd0)) begin
                load_pend <= 1'b0;
            end

            if (!en || blank) begin
                an  <= 4'b1111;
                seg <= SEG_OFF;
                dp  <= DP_OFF;
            end else begin
                an  <= ~(4'b0001 << dig);
                seg <= seg_lit;
                dp  <= snap_dp[dig] ? ~DP_OFF : DP_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-arithmetic reference model queues the
// expected display per clock edge, and a monitor compares the DUT outputs after each edge.
module tb_seg7_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in0 = 4'h0, in1 = 4'h0, in2 = 4'h0, in3 = 4'h0;
    logic [3:0] dp_sel = 4'h0;
    logic       blank_lz = 1'b0;
    logic       en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SD), .ACTIVE_LOW_SEG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .dp_sel(dp_sel), .blank_lz(blank_lz), .en(en),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    logic       st_rst = 1'b1;
    logic       st_en  = 1'b0;
    logic [3:0] st_in [4];
    logic [3:0] st_dp = 4'h0;
    logic       st_lz = 1'b0;

    // Reference: n_en counts enabled edges since reset; slot and frame follow by division.
    int         n_en = 0;
    logic [3:0] m_snap [4];
    logic [3:0] m_dp = 4'h0;
    logic       m_lz = 1'b0;

    task automatic model_push();
        exp_t e;
        int   pos, d;
        bit   blank;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
        if (st_rst) begin
            n_en = 0;
            for (int j = 0; j < 4; j++) m_snap[j] = 4'h0;
            m_dp = 4'h0;
            m_lz = 1'b0;
        end else if (st_en) begin
            pos   = n_en % FRAME;
            d     = pos / SD;
            blank = m_lz && (d > 0);
            for (int j = d; j < 4; j++) if (m_snap[j] != 4'h0) blank = 1'b0;
            if (!blank) begin
                e.an[d] = 1'b0;
                e.seg   = ~HEX[m_snap[d]];
                e.dp    = ~m_dp[d];
            end
            e.fs = (pos == 0) && (n_en >= FRAME);
            if (pos == FRAME - 1) begin
                for (int j = 0; j < 4; j++) m_snap[j] = st_in[j];
                m_dp = st_dp;
                m_lz = st_lz;
            end
            n_en++;
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            rst      = st_rst;
            en       = st_en;
            in0      = st_in[0];
            in1      = st_in[1];
            in2      = st_in[2];
            in3      = st_in[3];
            dp_sel   = st_dp;
            blank_lz = st_lz;
            model_push();
        end
    endtask

    task automatic wait_pos(input int d, input int k);
        int g;
        g = 0;
        while (!((((n_en / SD) % 4) == d) && ((n_en % SD) == k)) && g < 200) begin
            cyc(1);
            g++;
        end
        if (g >= 200) begin
            n_bad++;
            $display("FAIL wait_pos timeout: slot %0d/%0d not reached, n_en=%0d", d, k, n_en);
        end
    endtask

    task automatic chk_now(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] rnd_nib();
        return (($urandom % 3) == 0) ? 4'h0 : 4'($urandom % 16);
    endfunction

    // Monitor: one queued expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (!done && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
                    n_bad++;
                    $display("FAIL scan_out t=%0t: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                             $time, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
                end
            end
        end
    end

    initial begin
        for (int j = 0; j < 4; j++) begin
            st_in[j]  = 4'h0;
            m_snap[j] = 4'h0;
        end
        st_rst = 1'b1;
        st_en  = 1'b1;

        @(posedge clk);
        #2;
        chk_now("reset_an", {4'h0, an}, 8'h0F);
        chk_now("reset_seg", {1'b0, seg}, 8'h7F);
        chk_now("reset_dp_fs", {6'h0, dp, frame_start}, 8'h02);

        cyc(3);
        st_rst = 1'b0;
        cyc(10);
        // Decode sweep: F A 9 1 on digits 3..0
        st_in[3] = 4'hF; st_in[2] = 4'hA; st_in[1] = 4'h9; st_in[0] = 4'h1;
        cyc(6 + 2 * FRAME);

        // Leading-zero blanking, then an all-zero display
        st_lz = 1'b1;
        st_in[3] = 4'h0; st_in[2] = 4'h0; st_in[1] = 4'h7; st_in[0] = 4'h0;
        cyc(2 * FRAME);
        st_in[1] = 4'h0;
        cyc(2 * FRAME);

        // Snapshot integrity: in0 changes from 3 to 5 during digit 1 slot
        st_lz = 1'b0;
        st_in[0] = 4'h3;
        cyc(FRAME);
        wait_pos(1, 0);
        st_in[0] = 4'h5;
        cyc(2 * FRAME + 8);

        // Enable gap in the middle of digit 2, with dp requested on digit 2
        st_dp = 4'b0100;
        st_in[3] = 4'h2; st_in[2] = 4'hC; st_in[1] = 4'h8;
        cyc(FRAME);
        wait_pos(2, 1);
        st_en = 1'b0;
        cyc(10);
        st_en = 1'b1;
        cyc(FRAME + 8);

        repeat (300) begin
            for (int j = 0; j < 4; j++) st_in[j] = rnd_nib();
            st_dp = 4'($urandom % 16);
            st_lz = 1'($urandom % 2);
            st_en = (($urandom % 8) != 0);
            cyc(1 + int'($urandom % 3));
        end

        // Asynchronous reset between edges
        st_en = 1'b1;
        cyc(FRAME + 5);
        @(posedge clk);
        #3;
        rst    = 1'b1;
        st_rst = 1'b1;
        #1;
        chk_now("async_rst_an", {4'h0, an}, 8'h0F);
        chk_now("async_rst_fs_seg", {frame_start, seg}, 8'h7F);
        cyc(3);
        st_rst = 1'b0;
        cyc(2 * FRAME + 3);

        repeat (150) begin
            for (int j = 0; j < 4; j++) st_in[j] = rnd_nib();
            st_dp = 4'($urandom % 16);
            st_lz = 1'($urandom % 2);
            st_en = (($urandom % 6) != 0);
            cyc(1 + int'($urandom % 4));
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
